// File: rtl/vmx_pkg.sv
// Shared definitions for the vector-multiply execute path: default geometry,
// product width derivation and result-collector FSM encoding.
package vmx_pkg;

   localparam int unsigned ARRAY_SIZE_DEF     = 4;
   localparam int unsigned VECTORS_BITLEN_DEF = 16;
   localparam int unsigned FRAME_BITLEN_DEF   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EMIT  = 2'd2
   } vmx_state_e;

   // A full-precision product of two operands needs twice the operand width.
   function automatic int unsigned product_bitlen(input int unsigned vec_bitlen);
      return 2 * vec_bitlen;
   endfunction

endpackage

// File: rtl/util_shift_unloader.sv
// Parallel-load shift register: captures a packed row of NUM_ELEMS elements and
// shifts one element toward lane 0 per shift pulse; lane 0 is presented on dout.
module util_shift_unloader #(
   parameter int unsigned ELEM_W    = 32,
   parameter int unsigned NUM_ELEMS = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load,
   input  logic [ELEM_W*NUM_ELEMS-1:0] din,
   input  logic                        shift,
   output logic [ELEM_W-1:0]           dout
);

   localparam int unsigned ROW_W = ELEM_W * NUM_ELEMS;

   logic [ROW_W-1:0] row_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_q <= '0;
      end else if (load) begin
         row_q <= din;
      end else if (shift) begin
         row_q <= row_q >> ELEM_W;
      end
   end

   assign dout = row_q[ELEM_W-1:0];

endmodule

// File: rtl/vmx_result_collector.sv
// Drains packed product rows from the eaq FIFO and serializes them, lane 0 first,
// onto a valid/ready stream with frame framing on m_tlast.
module vmx_result_collector
   import vmx_pkg::*;
#(
   parameter  int unsigned ARRAY_SIZE     = ARRAY_SIZE_DEF,
   parameter  int unsigned VECTORS_BITLEN = VECTORS_BITLEN_DEF,
   parameter  int unsigned FRAME_BITLEN   = FRAME_BITLEN_DEF,
   localparam int unsigned PRODUCT_BITLEN = product_bitlen(VECTORS_BITLEN)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [PRODUCT_BITLEN*ARRAY_SIZE-1:0] eaq_fifo_dout,
   input  logic                                 eaq_fifo_empty,
   output logic                                 eaq_fifo_rden,
   input  logic [FRAME_BITLEN-1:0]              frame_len,
   output logic [PRODUCT_BITLEN-1:0]            m_tdata,
   output logic                                 m_tvalid,
   input  logic                                 m_tready,
   output logic                                 m_tlast,
   output logic                                 busy,
   output logic                                 frame_done
);

   localparam int unsigned LANE_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(ARRAY_SIZE - 1);

   vmx_state_e              state;
   vmx_state_e              state_nxt;
   logic [LANE_W-1:0]       lane;
   logic [FRAME_BITLEN-1:0] row_cnt;
   logic [FRAME_BITLEN-1:0] frame_len_q;
   logic                    load;
   logic                    beat;
   logic                    row_end;

   assign load     = (state == FETCH);
   assign m_tvalid = (state == EMIT);
   assign busy     = (state != IDLE);
   assign beat     = m_tvalid & m_tready;
   assign row_end  = beat & (lane == LAST_LANE);
   assign m_tlast  = m_tvalid & (lane == LAST_LANE)
                   & (row_cnt == (frame_len_q - FRAME_BITLEN'(1)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The final beat of a row pops the next one early so FETCH overlaps the drain.
   always_comb begin
      state_nxt     = state;
      eaq_fifo_rden = 1'b0;
      case (state)
         IDLE: begin
            eaq_fifo_rden = ~eaq_fifo_empty;
            if (!eaq_fifo_empty) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            state_nxt = EMIT;
         end
         EMIT: begin
            if (row_end) begin
               eaq_fifo_rden = ~eaq_fifo_empty;
               state_nxt     = eaq_fifo_empty ? IDLE : FETCH;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Lane/row bookkeeping; frame length is only sampled at the first row of a frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane        <= '0;
         row_cnt     <= '0;
         frame_len_q <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= beat & m_tlast;
         if (load) begin
            lane <= '0;
            if (row_cnt == '0) begin
               frame_len_q <= (frame_len == '0) ? FRAME_BITLEN'(1) : frame_len;
            end
         end else if (beat) begin
            if (lane != LAST_LANE) begin
               lane <= lane + LANE_W'(1);
            end else begin
               row_cnt <= m_tlast ? '0 : row_cnt + FRAME_BITLEN'(1);
            end
         end
      end
   end

   util_shift_unloader #(
      .ELEM_W    (PRODUCT_BITLEN),
      .NUM_ELEMS (ARRAY_SIZE)
   ) u_unloader (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .din   (eaq_fifo_dout),
      .shift (beat),
      .dout  (m_tdata)
   );

endmodule

// File: tb/tb_vmx_result_collector.sv
// Bench for vmx_result_collector: FIFO model feeding rows, scoreboard of expected
// {last,data} words consumed by a stream monitor, and per-scenario checks.
module tb_vmx_result_collector;

   localparam int unsigned PW = 32;
   localparam int unsigned AS = 4;
   localparam int unsigned FW = 16;
   localparam int unsigned RW = PW * AS;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [RW-1:0] eaq_fifo_dout;
   logic          eaq_fifo_empty;
   logic          eaq_fifo_rden;
   logic [FW-1:0] frame_len;
   logic [PW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic          m_tlast;
   logic          busy;
   logic          frame_done;

   int checks   = 0;
   int failures = 0;

   logic [RW-1:0] push_q[$];
   logic [PW:0]   exp_q[$];
   int            exp_base = 0;
   int            sb_row   = 0;
   int            sb_flen  = 1;

   int   cyc       = 0;
   int   exp_rd    = 0;
   int   beat_cnt  = 0;
   int   last_cnt  = 0;
   int   fd_cnt    = 0;
   int   rden_cnt  = 0;
   int   gap_cnt   = 0;
   int   efall_cyc = 0;
   int   beat_cyc[$];

   always #5 clk = ~clk;

   vmx_result_collector dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .eaq_fifo_dout  (eaq_fifo_dout),
      .eaq_fifo_empty (eaq_fifo_empty),
      .eaq_fifo_rden  (eaq_fifo_rden),
      .frame_len      (frame_len),
      .m_tdata        (m_tdata),
      .m_tvalid       (m_tvalid),
      .m_tready       (m_tready),
      .m_tlast        (m_tlast),
      .busy           (busy),
      .frame_done     (frame_done)
   );

   // FIFO model: data valid the cycle after rden; pushes become visible at the next edge.
   initial begin
      logic [RW-1:0] rows_q[$];
      int taken;
      taken          = 0;
      eaq_fifo_empty = 1'b1;
      eaq_fifo_dout  = '0;
      forever begin
         @(posedge clk);
         if (eaq_fifo_rden && rows_q.size() != 0) eaq_fifo_dout <= rows_q.pop_front();
         while (taken < push_q.size()) begin
            rows_q.push_back(push_q[taken]);
            taken++;
         end
         eaq_fifo_empty <= (rows_q.size() == 0);
      end
   end

   // Stream monitor: scoreboard pops, stall stability, rden legality, frame_done timing.
   initial begin
      logic          prev_stall;
      logic          prev_lastbeat;
      logic          prev_empty;
      logic [PW-1:0] prev_data;
      logic          prev_tlast;
      prev_stall    = 1'b0;
      prev_lastbeat = 1'b0;
      prev_empty    = 1'b1;
      prev_data     = '0;
      prev_tlast    = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_stall    = 1'b0;
            prev_lastbeat = 1'b0;
         end else begin
            if (prev_empty && !eaq_fifo_empty) efall_cyc = cyc;
            if (eaq_fifo_rden === 1'b1) rden_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
            if (busy && !m_tvalid) gap_cnt++;
            checks++;
            if (frame_done !== prev_lastbeat) begin
               failures++;
               $display("FAIL frame_done_timing: got %b want %b at cycle %0d", frame_done, prev_lastbeat, cyc);
            end
            checks++;
            if (eaq_fifo_rden === 1'b1 && (eaq_fifo_empty || (m_tvalid && !m_tready))) begin
               failures++;
               $display("FAIL rden_illegal: got rden=1 want 0 (empty=%b stalled=%b) at cycle %0d",
                        eaq_fifo_empty, m_tvalid && !m_tready, cyc);
            end
            if (prev_stall) begin
               checks++;
               if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_tlast) begin
                  failures++;
                  $display("FAIL stall_hold: got valid=%b data=%h last=%b want valid=1 data=%h last=%b at cycle %0d",
                           m_tvalid, m_tdata, m_tlast, prev_data, prev_tlast, cyc);
               end
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
               beat_cnt++;
               beat_cyc.push_back(cyc);
               if (m_tlast) last_cnt++;
               if (exp_rd < exp_base) exp_rd = exp_base;
               checks++;
               if (exp_rd >= exp_q.size()) begin
                  failures++;
                  $display("FAIL sb_unexpected_beat: got data=%h last=%b want no beat at cycle %0d",
                           m_tdata, m_tlast, cyc);
               end else begin
                  if ({m_tlast, m_tdata} !== exp_q[exp_rd]) begin
                     failures++;
                     $display("FAIL sb_beat[%0d]: got last=%b data=%h want last=%b data=%h",
                              exp_rd, m_tlast, m_tdata, exp_q[exp_rd][PW], exp_q[exp_rd][PW-1:0]);
                  end
                  exp_rd++;
               end
            end
            prev_stall    = m_tvalid && !m_tready;
            prev_data     = m_tdata;
            prev_tlast    = m_tlast;
            prev_lastbeat = m_tvalid && m_tready && m_tlast;
         end
         prev_empty = eaq_fifo_empty;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [RW-1:0] make_row(input logic [PW-1:0] b);
      return {b + PW'(3), b + PW'(2), b + PW'(1), b};
   endfunction

   // Queue a row to the FIFO and its expected words to the scoreboard.
   task automatic push_row(input logic [RW-1:0] row);
      logic last;
      if (sb_row == 0) sb_flen = (frame_len == '0) ? 1 : int'(frame_len);
      push_q.push_back(row);
      for (int i = 0; i < int'(AS); i++) begin
         last = (i == int'(AS) - 1) && (sb_row == sb_flen - 1);
         exp_q.push_back({last, row[i*PW +: PW]});
      end
      sb_row = (sb_row == sb_flen - 1) ? 0 : sb_row + 1;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n;
      n = 0;
      while (n < budget && !(exp_rd >= exp_q.size() && !busy && eaq_fifo_empty)) begin
         tick(1);
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL %s_timeout: got %0d of %0d words after %0d cycles", name, exp_rd, exp_q.size(), n);
      end
      tick(2);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick(3);
      checks++;
      if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
      checks++;
      if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
      checks++;
      if (m_tdata !== '0) begin failures++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      checks++;
      if (eaq_fifo_rden !== 1'b0) begin failures++; $display("FAIL reset_rden: got %b want 0", eaq_fifo_rden); end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_single_row;
      int b0, l0, f0, r0, span, lat;
      b0 = beat_cnt; l0 = last_cnt; f0 = fd_cnt; r0 = rden_cnt;
      frame_len = 16'd1;
      m_tready  = 1'b1;
      push_row(make_row(32'h1));
      wait_done(40, "single");
      span = (beat_cnt - b0 >= 4) ? beat_cyc[b0+3] - beat_cyc[b0] : -1;
      lat  = (beat_cnt - b0 >= 1) ? beat_cyc[b0] - efall_cyc : -1;
      checks++;
      if (beat_cnt - b0 != 4) begin failures++; $display("FAIL single_beats: got %0d want 4", beat_cnt - b0); end
      checks++;
      if (span != 3) begin failures++; $display("FAIL single_span: got %0d want 3", span); end
      checks++;
      if (lat != 2) begin failures++; $display("FAIL single_latency: got %0d want 2", lat); end
      checks++;
      if (last_cnt - l0 != 1) begin failures++; $display("FAIL single_tlast: got %0d want 1", last_cnt - l0); end
      checks++;
      if (fd_cnt - f0 != 1) begin failures++; $display("FAIL single_frame_done: got %0d want 1", fd_cnt - f0); end
      checks++;
      if (rden_cnt - r0 != 1) begin failures++; $display("FAIL single_rden: got %0d want 1", rden_cnt - r0); end
   endtask

   task automatic test_three_rows;
      int b0, l0, f0, r0, g0, span;
      b0 = beat_cnt; l0 = last_cnt; f0 = fd_cnt; r0 = rden_cnt; g0 = gap_cnt;
      frame_len = 16'd3;
      push_row(make_row(32'h10));
      push_row(make_row(32'h20));
      push_row(make_row(32'h30));
      wait_done(80, "three");
      span = (beat_cnt - b0 >= 12) ? beat_cyc[b0+11] - beat_cyc[b0] : -1;
      checks++;
      if (beat_cnt - b0 != 12) begin failures++; $display("FAIL three_beats: got %0d want 12", beat_cnt - b0); end
      checks++;
      if (span != 13) begin failures++; $display("FAIL three_span: got %0d want 13", span); end
      checks++;
      if (gap_cnt - g0 != 3) begin failures++; $display("FAIL three_gaps: got %0d want 3", gap_cnt - g0); end
      checks++;
      if (last_cnt - l0 != 1) begin failures++; $display("FAIL three_tlast: got %0d want 1", last_cnt - l0); end
      checks++;
      if (fd_cnt - f0 != 1) begin failures++; $display("FAIL three_frame_done: got %0d want 1", fd_cnt - f0); end
      checks++;
      if (rden_cnt - r0 != 3) begin failures++; $display("FAIL three_rden: got %0d want 3", rden_cnt - r0); end
   endtask

   task automatic test_backpressure;
      int b0, l0, f0, r0, n;
      logic [3:0] pat;
      pat = 4'b1001;
      b0 = beat_cnt; l0 = last_cnt; f0 = fd_cnt; r0 = rden_cnt;
      frame_len = 16'd2;
      push_row(make_row(32'h100));
      push_row(make_row(32'h200));
      n = 0;
      while (n < 200 && !(exp_rd >= exp_q.size() && !busy && eaq_fifo_empty)) begin
         m_tready = pat[n % 4];
         tick(1);
         n++;
      end
      m_tready = 1'b1;
      checks++;
      if (n >= 200) begin failures++; $display("FAIL bp_timeout: got %0d of %0d words", exp_rd, exp_q.size()); end
      tick(2);
      checks++;
      if (beat_cnt - b0 != 8) begin failures++; $display("FAIL bp_beats: got %0d want 8", beat_cnt - b0); end
      checks++;
      if (last_cnt - l0 != 1) begin failures++; $display("FAIL bp_tlast: got %0d want 1", last_cnt - l0); end
      checks++;
      if (fd_cnt - f0 != 1) begin failures++; $display("FAIL bp_frame_done: got %0d want 1", fd_cnt - f0); end
      checks++;
      if (rden_cnt - r0 != 2) begin failures++; $display("FAIL bp_rden: got %0d want 2", rden_cnt - r0); end
   endtask

   task automatic test_empty_gap;
      int b0, lat;
      frame_len = 16'd1;
      push_row(make_row(32'h300));
      wait_done(40, "gap_first");
      for (int i = 0; i < 10; i++) begin
         tick(1);
         checks++;
         if (busy !== 1'b0 || eaq_fifo_rden !== 1'b0) begin
            failures++;
            $display("FAIL gap_parked: got busy=%b rden=%b want busy=0 rden=0", busy, eaq_fifo_rden);
         end
      end
      b0 = beat_cnt;
      push_row(make_row(32'h400));
      wait_done(40, "gap_second");
      lat = (beat_cnt - b0 >= 1) ? beat_cyc[b0] - efall_cyc : -1;
      checks++;
      if (beat_cnt - b0 != 4) begin failures++; $display("FAIL gap_beats: got %0d want 4", beat_cnt - b0); end
      checks++;
      if (lat != 2) begin failures++; $display("FAIL gap_latency: got %0d want 2", lat); end
   endtask

   task automatic test_frame_len_zero;
      int b0, l0, f0;
      b0 = beat_cnt; l0 = last_cnt; f0 = fd_cnt;
      frame_len = 16'd0;
      push_row(make_row(32'h500));
      push_row(make_row(32'h600));
      wait_done(60, "flen0");
      checks++;
      if (beat_cnt - b0 != 8) begin failures++; $display("FAIL flen0_beats: got %0d want 8", beat_cnt - b0); end
      checks++;
      if (last_cnt - l0 != 2) begin failures++; $display("FAIL flen0_tlast: got %0d want 2", last_cnt - l0); end
      checks++;
      if (fd_cnt - f0 != 2) begin failures++; $display("FAIL flen0_frame_done: got %0d want 2", fd_cnt - f0); end
   endtask

   task automatic test_reset_mid;
      int b0, l0, f0, e0, n;
      b0 = beat_cnt; l0 = last_cnt; f0 = fd_cnt; e0 = exp_q.size();
      frame_len = 16'd2;
      push_row(make_row(32'h700));
      n = 0;
      while (n < 40 && beat_cnt < b0 + 1) begin
         tick(1);
         n++;
      end
      checks++;
      if (n >= 40) begin failures++; $display("FAIL rmid_first_beat_timeout: got %0d beats want 1", beat_cnt - b0); end
      // The DUT now presents the 2nd lane; abort it and drop the rest of the row.
      rst_n    = 1'b0;
      exp_base = e0 + int'(AS);
      sb_row   = 0;
      tick(1);
      checks++;
      if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rmid_tvalid: got %b want 0", m_tvalid); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      tick(1);
      push_row(make_row(32'h800));
      push_row(make_row(32'h900));
      wait_done(60, "rmid");
      checks++;
      if (beat_cnt - b0 != 9) begin failures++; $display("FAIL rmid_beats: got %0d want 9", beat_cnt - b0); end
      checks++;
      if (last_cnt - l0 != 1) begin failures++; $display("FAIL rmid_tlast: got %0d want 1", last_cnt - l0); end
      checks++;
      if (fd_cnt - f0 != 1) begin failures++; $display("FAIL rmid_frame_done: got %0d want 1", fd_cnt - f0); end
   endtask

   initial begin
      rst_n     = 1'b0;
      m_tready  = 1'b1;
      frame_len = 16'd1;
      test_reset;
      test_single_row;
      test_three_rows;
      test_backpressure;
      test_empty_gap;
      test_frame_len_zero;
      test_reset_mid;
      tick(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
